// File: rtl/aes_stream_sequencer.sv
// aes_stream_sequencer
// Valid/ready front end for the AES core. It loads a key once, then sends one block
// at a time through the core's init/next/enc_ready handshake. Each result is held on
// a registered output until downstream takes it.
// Optional feature macro: AES_CBC_EN. When defined, blocks are chained in CBC mode.
// Otherwise blocks are sent straight through (ECB).
module aes_stream_sequencer #(
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] iv_in,
  input  logic [127:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  output logic         core_init,
  output logic         core_next,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         err,
  output logic [31:0]  blk_count
);

  localparam int unsigned PulseW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned ToutW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(PULSE_CYCLES - 1);
  localparam logic [ToutW-1:0]  ToutLast  = ToutW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, KINIT, KWAIT, READY, NPULSE, NDROP, NWAIT, OUT
  } seqStateE;

  seqStateE          state;
  logic [PulseW-1:0] pulseCnt;
  logic [ToutW-1:0]  toutCnt;
  logic              keyLoaded;
  logic              sReadyQ;
  logic              keyAccept;
  logic              blkAccept;
  logic              waitState;
  logic              waitExit;
  logic              toutHit;

`ifdef AES_CBC_EN
  logic [127:0] chain;
`else
  logic unusedIv;
  assign unusedIv = ^iv_in;
`endif

  // A key offered in the same cycle as a block wins, so s_ready follows key_valid low.
  assign s_ready   = sReadyQ & keyLoaded & ~key_valid;
  assign keyAccept = key_ready & key_valid;
  assign blkAccept = s_ready & s_valid;

  // The wait states share one timeout counter. The abort fires only when the awaited event has not arrived.
  assign waitState = (state == KWAIT) || (state == NDROP) || (state == NWAIT);
  assign waitExit  = ((state == KWAIT) && core_ready) ||
                     ((state == NDROP) && !core_ready) ||
                     ((state == NWAIT) && core_ready);
  assign toutHit   = waitState && !waitExit && (toutCnt == ToutLast);

  // Sequencer FSM with registered core, stream and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pulseCnt   <= '0;
      toutCnt    <= '0;
      keyLoaded  <= 1'b0;
      sReadyQ    <= 1'b0;
      key_ready  <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      core_key   <= '0;
      core_block <= '0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      blk_count  <= '0;
`ifdef AES_CBC_EN
      chain      <= '0;
`endif
    end else begin
      if (waitState) toutCnt <= toutCnt + ToutW'(1);

      if (keyAccept) begin
        // A new key restarts expansion from IDLE or READY and resets the stream
        state     <= KINIT;
        core_key  <= key_in;
        core_init <= 1'b1;
        pulseCnt  <= '0;
        keyLoaded <= 1'b0;
        key_ready <= 1'b0;
        sReadyQ   <= 1'b0;
        busy      <= 1'b1;
        err       <= 1'b0;
        blk_count <= '0;
`ifdef AES_CBC_EN
        chain     <= iv_in;
`endif
      end else if (toutHit) begin
        // The core stopped responding, so drop any in-flight block and require a fresh key
        state     <= IDLE;
        core_init <= 1'b0;
        core_next <= 1'b0;
        keyLoaded <= 1'b0;
        key_ready <= 1'b1;
        sReadyQ   <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
`ifdef AES_CBC_EN
        chain     <= '0;
`endif
      end else begin
        case (state)
          IDLE: key_ready <= 1'b1;
          KINIT: begin
            pulseCnt <= pulseCnt + PulseW'(1);
            if (pulseCnt == PulseLast) begin
              core_init <= 1'b0;
              toutCnt   <= '0;
              state     <= KWAIT;
            end
          end
          KWAIT: begin
            if (core_ready) begin
              keyLoaded <= 1'b1;
              key_ready <= 1'b1;
              sReadyQ   <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end
          end
          READY: begin
            if (blkAccept) begin
`ifdef AES_CBC_EN
              core_block <= s_data ^ chain;
`else
              core_block <= s_data;
`endif
              core_next  <= 1'b1;
              pulseCnt   <= '0;
              key_ready  <= 1'b0;
              sReadyQ    <= 1'b0;
              busy       <= 1'b1;
              state      <= NPULSE;
            end
          end
          NPULSE: begin
            pulseCnt <= pulseCnt + PulseW'(1);
            if (pulseCnt == PulseLast) begin
              core_next <= 1'b0;
              toutCnt   <= '0;
              state     <= NDROP;
            end
          end
          NDROP: begin
            if (!core_ready) begin
              toutCnt <= '0;
              state   <= NWAIT;
            end
          end
          NWAIT: begin
            if (core_ready) begin
              m_data  <= core_result;
              m_valid <= 1'b1;
`ifdef AES_CBC_EN
              chain   <= core_result;
`endif
              state   <= OUT;
            end
          end
          OUT: begin
            if (m_ready) begin
              m_valid   <= 1'b0;
              blk_count <= blk_count + 32'd1;
              key_ready <= 1'b1;
              sReadyQ   <= 1'b1;
              busy      <= 1'b0;
              state     <= READY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// tb_aes_stream_sequencer
// Bench for aes_stream_sequencer. It drives the sequencer against a stub core:
// enc_ready stays low for 10 cycles after init/next falls, then result = block ^ key.
// Results are checked against a block-level model of ECB/CBC chaining. The optional
// AES_CBC_EN macro selects CBC mode in both the DUT and the model.
`timescale 1ns/1ps
module tb_aes_stream_sequencer;

  localparam int unsigned PULSE = 2;
  localparam int unsigned TOUT  = 16;
`ifdef AES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] keyIn, ivIn, sData, mData, coreKey, coreBlock;
  logic         keyValid, keyReady, sValid, sReady, mValid, mReady;
  logic         coreInit, coreNext, busy, err;
  logic [31:0]  blkCount;

  logic         stubReady, stubDead;
  logic [7:0]   stubCnt;
  logic [127:0] stubResult;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] mdlKey, mdlChain;
  logic [31:0]  mdlCount;

  aes_stream_sequencer #(.PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset),
    .key_in(keyIn), .key_valid(keyValid), .key_ready(keyReady), .iv_in(ivIn),
    .s_data(sData), .s_valid(sValid), .s_ready(sReady),
    .m_data(mData), .m_valid(mValid), .m_ready(mReady),
    .core_key(coreKey), .core_block(coreBlock), .core_init(coreInit), .core_next(coreNext),
    .core_ready(stubReady), .core_result(stubResult),
    .busy(busy), .err(err), .blk_count(blkCount)
  );

  always #5 clk = ~clk;

  // Stub core: drops enc_ready on a request, raises it 10 cycles after the request falls
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stubReady  <= 1'b1;
      stubCnt    <= 8'd0;
      stubResult <= '0;
    end else if (coreInit || coreNext) begin
      stubReady  <= 1'b0;
      stubCnt    <= 8'd10;
      stubResult <= coreBlock ^ coreKey;
    end else if (stubCnt != 8'd0) begin
      stubCnt <= stubCnt - 8'd1;
      if (stubCnt == 8'd1 && !stubDead) stubReady <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  task automatic mdlLoadKey(input logic [127:0] k, input logic [127:0] v);
    mdlKey   = k;
    mdlChain = CBC ? v : 128'd0;
    mdlCount = 32'd0;
  endtask

  task automatic mdlStep(input logic [127:0] d, output logic [127:0] r);
    r = (CBC ? (d ^ mdlChain) : d) ^ mdlKey;
    if (CBC) mdlChain = r;
    mdlCount = mdlCount + 32'd1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic doKey(input logic [127:0] k, input logic [127:0] v, output bit ok);
    keyIn = k; ivIn = v; keyValid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (keyReady) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    keyValid = 1'b0;
  endtask

  task automatic waitReady(output int initHigh, output int nextHigh, output bit ok);
    initHigh = 0; nextHigh = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (coreInit) initHigh++;
      if (coreNext) nextHigh++;
      if (!busy && keyReady) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic sendBlock(input logic [127:0] d, output bit ok);
    sData = d; sValid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sReady) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    sValid = 1'b0;
  endtask

  task automatic waitMValid(output int nextHigh, output bit ok);
    nextHigh = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (coreNext) nextHigh++;
      if (mValid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic runBlock(input logic [127:0] d, input int hold,
                          output logic [127:0] got, output int nextHigh, output bit ok);
    got = '0; nextHigh = 0;
    sendBlock(d, ok);
    if (!ok) return;
    waitMValid(nextHigh, ok);
    if (!ok) return;
    got = mData;
    repeat (hold) @(negedge clk);
    mReady = 1'b1;
    @(negedge clk);
    mReady = 1'b0;
  endtask

  task automatic loadAndWait(input logic [127:0] k, input logic [127:0] v, input string tag);
    bit ok; int ih; int nh;
    doKey(k, v, ok);
    if (ok) waitReady(ih, nh, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_key_load timed out waiting for READY", tag); end
    mdlLoadKey(k, v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; keyIn = rnd128(); keyValid = 1'b1; sValid = 1'b1; mReady = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (keyReady !== 1'b0) begin miscompares++; $display("FAIL reset_key_ready got %b want 0", keyReady); end
    vectors++; if (sReady !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got %b want 0", sReady); end
    vectors++; if (mValid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b want 0", mValid); end
    vectors++; if (coreInit !== 1'b0 || coreNext !== 1'b0) begin miscompares++; $display("FAIL reset_core_ctl got %b%b want 00", coreInit, coreNext); end
    vectors++; if ({busy, err, blkCount, mData, coreKey, coreBlock} !== '0) begin miscompares++; $display("FAIL reset_outputs got nonzero want 0"); end
    keyValid = 1'b0; sValid = 1'b0; mReady = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (keyReady !== 1'b1) begin miscompares++; $display("FAIL idle_key_ready got %b want 1", keyReady); end
    vectors++; if (busy !== 1'b0 || sReady !== 1'b0) begin miscompares++; $display("FAIL idle_busy_s_ready got %b%b want 00", busy, sReady); end
  endtask

  task automatic test_known_vector();
    bit ok; int ih; int nh; logic [127:0] got, want;
    doKey(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0, ok);
    if (ok) waitReady(ih, nh, ok);
    mdlLoadKey(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0);
    vectors++; if (!ok || ih != PULSE) begin miscompares++; $display("FAIL kv_core_init_cycles got %0d want %0d", ih, PULSE); end
    runBlock(128'h6bc1bee22e409f96e93d7e117393172a, 0, got, nh, ok);
    mdlStep(128'h6bc1bee22e409f96e93d7e117393172a, want);
    vectors++; if (!ok || got !== 128'h40bfabf406ee4d3042ca6b997a5c5816) begin miscompares++; $display("FAIL kv_m_data got %h want 40bfabf406ee4d3042ca6b997a5c5816", got); end
    vectors++; if (got !== want) begin miscompares++; $display("FAIL kv_model got %h want %h", got, want); end
    vectors++; if (nh != PULSE) begin miscompares++; $display("FAIL kv_core_next_cycles got %0d want %0d", nh, PULSE); end
    vectors++; if (blkCount !== mdlCount) begin miscompares++; $display("FAIL kv_blk_count got %0d want %0d", blkCount, mdlCount); end
  endtask

  task automatic test_backpressure();
    bit ok; bit stable; int nh; logic [127:0] d, got, want;
    d = rnd128();
    sendBlock(d, ok);
    if (ok) waitMValid(nh, ok);
    mdlStep(d, want);
    got = mData;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mData !== got || mValid !== 1'b1 || sReady !== 1'b0) stable = 1'b0;
    end
    vectors++; if (!ok || !stable) begin miscompares++; $display("FAIL bp_hold_stable got ok=%b stable=%b want 1/1", ok, stable); end
    vectors++; if (got !== want) begin miscompares++; $display("FAIL bp_m_data got %h want %h", got, want); end
    mReady = 1'b1;
    @(negedge clk);
    mReady = 1'b0;
    vectors++; if (mValid !== 1'b0 || sReady !== 1'b1) begin miscompares++; $display("FAIL bp_release got m_valid=%b s_ready=%b want 0/1", mValid, sReady); end
    vectors++; if (blkCount !== mdlCount) begin miscompares++; $display("FAIL bp_blk_count got %0d want %0d", blkCount, mdlCount); end
  endtask

  task automatic test_key_priority();
    bit ok; int ih; int nh; logic [127:0] k, v;
    k = rnd128(); v = rnd128();
    keyIn = k; ivIn = v; keyValid = 1'b1; sData = rnd128(); sValid = 1'b1;
    #1;
    vectors++; if (sReady !== 1'b0 || keyReady !== 1'b1) begin miscompares++; $display("FAIL prio_ready got s=%b k=%b want 0/1", sReady, keyReady); end
    @(negedge clk);
    keyValid = 1'b0; sValid = 1'b0;
    vectors++; if (coreInit !== 1'b1 || busy !== 1'b1 || keyReady !== 1'b0) begin miscompares++; $display("FAIL prio_kinit got init=%b busy=%b kr=%b want 1/1/0", coreInit, busy, keyReady); end
    vectors++; if (blkCount !== 32'd0) begin miscompares++; $display("FAIL prio_blk_count got %0d want 0", blkCount); end
    waitReady(ih, nh, ok);
    mdlLoadKey(k, v);
    vectors++; if (!ok || nh != 0 || ih != PULSE) begin miscompares++; $display("FAIL prio_no_block got next=%0d init=%0d want 0/%0d", nh, ih, PULSE); end
  endtask

  task automatic test_timeout();
    bit ok; bit sawM; int cnt; int nh;
    stubDead = 1'b1;
    doKey(rnd128(), rnd128(), ok);
    cnt = 0; sawM = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (err) break;
      if (mValid) sawM = 1'b1;
      @(negedge clk);
      cnt++;
    end
    vectors++; if (err !== 1'b1 || cnt != PULSE + TOUT) begin miscompares++; $display("FAIL tout_key_err got err=%b after %0d want 1 after %0d", err, cnt, PULSE + TOUT); end
    vectors++; if (busy !== 1'b0 || keyReady !== 1'b1 || coreInit !== 1'b0 || sawM) begin miscompares++; $display("FAIL tout_key_idle got busy=%b kr=%b init=%b m=%b want 0/1/0/0", busy, keyReady, coreInit, sawM); end
    stubDead = 1'b0;
    doKey(rnd128(), rnd128(), ok);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL tout_err_clear got %b want 0", err); end
    loadAndWait(rnd128(), rnd128(), "tout_reload");
    stubDead = 1'b1;
    sendBlock(rnd128(), ok);
    sawM = 1'b0; nh = 0;
    for (int i = 0; i < 100; i++) begin
      if (err) break;
      if (mValid) sawM = 1'b1;
      if (coreNext) nh++;
      @(negedge clk);
    end
    vectors++; if (err !== 1'b1 || sawM || busy !== 1'b0 || coreNext !== 1'b0) begin miscompares++; $display("FAIL tout_block got err=%b m=%b busy=%b next=%b want 1/0/0/0", err, sawM, busy, coreNext); end
    stubDead = 1'b0;
    loadAndWait(rnd128(), rnd128(), "tout_recover");
    vectors++; if (err !== 1'b0 || blkCount !== 32'd0) begin miscompares++; $display("FAIL tout_recover got err=%b cnt=%0d want 0/0", err, blkCount); end
  endtask

  task automatic test_random();
    bit ok; int nh; logic [127:0] d, got, want;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) loadAndWait(rnd128(), rnd128(), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = rnd128();
      runBlock(d, int'($urandom_range(0, 3)), got, nh, ok);
      mdlStep(d, want);
      vectors++; if (!ok || got !== want) begin miscompares++; $display("FAIL rand_m_data[%0d] got %h want %h", it, got, want); end
      vectors++; if (blkCount !== mdlCount) begin miscompares++; $display("FAIL rand_blk_count[%0d] got %0d want %0d", it, blkCount, mdlCount); end
    end
  endtask

  task automatic test_chain_vector();
    bit ok; int nh; logic [127:0] got, want;
    loadAndWait(128'd0, 128'd1, "chain");
    for (int b = 0; b < 2; b++) begin
      runBlock(128'd0, 0, got, nh, ok);
      mdlStep(128'd0, want);
      vectors++; if (!ok || got !== want) begin miscompares++; $display("FAIL chain_block%0d got %h want %h", b, got, want); end
    end
  endtask

  initial begin
    reset = 1'b0; keyIn = '0; ivIn = '0; keyValid = 1'b0; sData = '0; sValid = 1'b0;
    mReady = 1'b0; stubDead = 1'b0;
    mdlKey = '0; mdlChain = '0; mdlCount = '0;
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_backpressure();
    test_key_priority();
    test_timeout();
    test_random();
    test_chain_vector();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

endmodule
